id_hazard_controller: RTL and testbench

ID_HAZARD_CONTROLLER -- requirements
Module: id_hazard_controller

---
 rtl/id_hazard_controller.sv | 151 +++++++++++++++
 tb/tb_id_hazard_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_controller.sv
// ID-stage hazard controller: load-use stall and taken-branch flush sequencing
// with saturating event counters for a classic 5-stage MIPS-style pipeline.
module id_hazard_controller #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [5:0]  id_opcode,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rt,
  input  logic        mem_branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  // state    | meaning
  // ST_RUN   | normal issue, hazard/branch evaluated
  // ST_STALL | extra load-use bubbles, r_cnt counts remaining-1
  // ST_FLUSH | extra flush cycles, r_cnt counts remaining-1
  // ST_UNUSED| unreachable, recovers to ST_RUN
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_UNUSED = 2'd3
  } state_t;

  // The first bubble/flush cycle happens in RUN (Mealy), so the counter
  // only covers the cycles after it.
  localparam logic [2:0] LP_STALL_RELOAD = 3'((STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0);
  localparam logic [2:0] LP_FLUSH_RELOAD = 3'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  logic w_uses_rt;
  logic w_hazard;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_idex_bubble;
  logic w_flush;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_uses_rt = (id_opcode == 6'b000000) || (id_opcode == 6'b000100) ||
                     (id_opcode == 6'b101011);

  assign w_hazard = ex_MemRead && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (w_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    w_state_nxt   = ST_RUN;
    w_cnt_nxt     = r_cnt;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_bubble = 1'b0;
    w_flush       = 1'b0;

    if (rst) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_cnt_nxt     = 3'd0;
    end else if (mem_branch_taken) begin
      // A taken branch overrides everything, including an in-progress stall.
      w_idex_bubble = 1'b1;
      w_flush       = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = LP_FLUSH_RELOAD;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            if (STALL_CYCLES > 1) begin
              w_state_nxt = ST_STALL;
              w_cnt_nxt   = LP_STALL_RELOAD;
            end
          end
        end
        ST_STALL: begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          if (r_cnt != 3'd0) begin
            w_state_nxt = ST_STALL;
            w_cnt_nxt   = r_cnt - 3'd1;
          end
        end
        ST_FLUSH: begin
          w_idex_bubble = 1'b1;
          w_flush       = 1'b1;
          if (r_cnt != 3'd0) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  assign w_stall_inc = w_idex_bubble && !w_flush && !rst;
  assign w_flush_inc = w_flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_cnt         <= 3'd0;
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall_inc && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (w_flush_inc && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign pc_write    = w_pc_write;
  assign ifid_write  = w_ifid_write;
  assign idex_bubble = w_idex_bubble;
  assign flush       = w_flush;
  assign state       = r_state;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_id_hazard_controller.sv
// Scoreboard bench: two parameterisations of id_hazard_controller share one
// stimulus stream and are checked against a remaining-cycles reference model.
module tb_id_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic [5:0] id_opcode;
  logic       ex_MemRead, mem_branch_taken;

  logic        pc0, ifid0, bub0, fl0, pc1, ifid1, bub1, fl1;
  logic [1:0]  st0, st1;
  logic [15:0] sc0, fc0, sc1, fc1;

  always #5 clk = ~clk;

  id_hazard_controller #(.STALL_CYCLES(1), .FLUSH_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_opcode(id_opcode),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .pc_write(pc0), .ifid_write(ifid0), .idex_bubble(bub0), .flush(fl0),
    .state(st0), .stall_count(sc0), .flush_count(fc0));

  id_hazard_controller #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_opcode(id_opcode),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .pc_write(pc1), .ifid_write(ifid1), .idex_bubble(bub1), .flush(fl1),
    .state(st1), .stall_count(sc1), .flush_count(fc1));

  typedef struct packed {
    logic        pc;
    logic        ifid;
    logic        bub;
    logic        fl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  // Reference model: cycles of stall / flush still owed after the current one.
  int s_par[2] = '{1, 3};
  int f_par[2] = '{1, 2};
  int stall_left[2] = '{0, 0};
  int flush_left[2] = '{0, 0};
  int m_sc[2] = '{0, 0};
  int m_fc[2] = '{0, 0};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic model_hazard();
    logic uses_rt;
    uses_rt = (id_opcode == 6'd0) || (id_opcode == 6'd4) || (id_opcode == 6'd43);
    return ex_MemRead && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic exp_t model_step(input int k);
    exp_t e;
    e.sc = 16'(m_sc[k]);
    e.fc = 16'(m_fc[k]);
    e.st = (flush_left[k] > 0) ? 2'd2 : (stall_left[k] > 0) ? 2'd1 : 2'd0;
    if (rst) begin
      {e.pc, e.ifid, e.bub, e.fl} = 4'b0010;
      stall_left[k] = 0;
      flush_left[k] = 0;
      m_sc[k] = 0;
      m_fc[k] = 0;
    end else begin
      if (mem_branch_taken) begin
        {e.pc, e.ifid, e.bub, e.fl} = 4'b1111;
        flush_left[k] = f_par[k] - 1;
        stall_left[k] = 0;
      end else if (flush_left[k] > 0) begin
        {e.pc, e.ifid, e.bub, e.fl} = 4'b1111;
        flush_left[k]--;
      end else if (stall_left[k] > 0) begin
        {e.pc, e.ifid, e.bub, e.fl} = 4'b0010;
        stall_left[k]--;
      end else if (model_hazard()) begin
        {e.pc, e.ifid, e.bub, e.fl} = 4'b0010;
        stall_left[k] = s_par[k] - 1;
      end else begin
        {e.pc, e.ifid, e.bub, e.fl} = 4'b1100;
      end
      if (e.bub && !e.fl && m_sc[k] < 65535) m_sc[k]++;
      if (e.fl && m_fc[k] < 65535) m_fc[k]++;
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic mr, input logic br,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] xrt, input logic [5:0] op);
    @(posedge clk);
    #1;
    rst = r; ex_MemRead = mr; mem_branch_taken = br;
    id_rs = rs; id_rt = rt; ex_rt = xrt; id_opcode = op;
    q0.push_back(model_step(0));
    q1.push_back(model_step(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 6'd0);
  endtask

  task automatic hazard_rtype();
    drive(1'b0, 1'b1, 1'b0, 5'd1, 5'd8, 5'd8, 6'b000000);
  endtask

  task automatic compare(input string tag, input exp_t a, input exp_t e);
    chk({tag, "_pc_write"},    16'(a.pc),   16'(e.pc));
    chk({tag, "_ifid_write"},  16'(a.ifid), 16'(e.ifid));
    chk({tag, "_idex_bubble"}, 16'(a.bub),  16'(e.bub));
    chk({tag, "_flush"},       16'(a.fl),   16'(e.fl));
    chk({tag, "_state"},       16'(a.st),   16'(e.st));
    chk({tag, "_stall_count"}, a.sc,        e.sc);
    chk({tag, "_flush_count"}, a.fc,        e.fc);
  endtask

  initial begin : monitor
    exp_t a;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        a = '{pc0, ifid0, bub0, fl0, st0, sc0, fc0};
        compare("dut0", a, q0.pop_front());
      end
      if (q1.size() > 0) begin
        a = '{pc1, ifid1, bub1, fl1, st1, sc1, fc1};
        compare("dut1", a, q1.pop_front());
      end
    end
  end

  initial begin : stimulus
    int ops[5] = '{0, 4, 43, 35, 8};
    rst = 1'b1; ex_MemRead = 1'b0; mem_branch_taken = 1'b0;
    id_rs = '0; id_rt = '0; ex_rt = '0; id_opcode = '0;
    repeat (2) @(posedge clk);

    drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd8, 6'd0);
    idle(2);
    // R-type reading the loaded register through rt
    hazard_rtype();
    idle(4);
    // lw does not read rt as a source
    drive(1'b0, 1'b1, 1'b0, 5'd3, 5'd8, 5'd8, 6'b100011);
    idle(2);
    // ex_rt = 0 never stalls
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 6'd0);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 6'b101011);
    idle(1);
    // branch in the second bubble cycle of a 3-cycle stall
    hazard_rtype();
    drive(1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 6'd0);
    idle(3);
    // back-to-back taken branches
    drive(1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 6'd0);
    drive(1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 6'd0);
    idle(3);
    // reset mid-stall and mid-flush
    hazard_rtype();
    drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd8, 5'd8, 6'd0);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 6'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 6'd0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 6'(ops[$urandom_range(0, 4)]));
    end

    // continuous hazards drive both stall counters into saturation
    drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 6'd0);
    for (int i = 0; i < 65540; i++) hazard_rtype();
    drive(1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 6'd0);
    idle(2);
    drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 5'd8, 6'd0);
    idle(3);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(q0.size() + q1.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
